// File: rtl/vga_pkg.sv
// Shared raster timing constants, board geometry and the pixel bundle type.
// Consumed by the timing generator and the grid renderer.
package vga_pkg;

    localparam int COORD_W = 10;

    localparam int VGA_CLK_DIV  = 2;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL =
        VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL =
        VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int CELL_W = 40;
    localparam int CELL_H = 30;
    localparam int GRID_W = 16;
    localparam int GRID_H = 16;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic   pix_en;
        coord_t x;
        coord_t y;
        logic   active;
        logic   hsync;
        logic   vsync;
        logic   line_start;
        logic   frame_start;
    } raster_t;

    localparam raster_t RASTER_RST = '{
        pix_en:      1'b0,
        x:           '0,
        y:           '0,
        active:      1'b0,
        hsync:       1'b1,
        vsync:       1'b1,
        line_start:  1'b0,
        frame_start: 1'b0
    };

    function automatic logic in_span(
        input coord_t c,
        input int     lo,
        input int     hi
    );
        return (int'(c) >= lo) && (int'(c) < hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster bundle from the timing generator to downstream display stages.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic   pix_en;
    coord_t xPixel;
    coord_t yPixel;
    logic   active_pixels;
    logic   hsync;
    logic   vsync;
    logic   line_start;
    logic   frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt;
`endif

    modport master (
        output pix_en,
        output xPixel,
        output yPixel,
        output active_pixels,
        output hsync,
        output vsync,
        output line_start,
`ifdef VGA_FRAME_CNT_EN
        output frame_cnt,
`endif
        output frame_start
    );

    modport slave (
        input pix_en,
        input xPixel,
        input yPixel,
        input active_pixels,
        input hsync,
        input vsync,
        input line_start,
`ifdef VGA_FRAME_CNT_EN
        input frame_cnt,
`endif
        input frame_start
    );

endinterface

// File: rtl/vga_timing_gen_clk_div_strobe.sv
// Pixel strobe divider: tick is high on the last system clock of each
// pixel period; DIV=1 yields a tick on every clock.
module clk_div_strobe #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CW = 5;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] div_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (div_cnt == LAST) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    assign tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480 raster timing generator: pixel strobe, h/v counters, syncs.
// Optional frame counter output enabled by VGA_FRAME_CNT_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV  = VGA_CLK_DIV,
    parameter int H_ACTIVE = VGA_H_ACTIVE,
    parameter int H_FP     = VGA_H_FP,
    parameter int H_SYNC   = VGA_H_SYNC,
    parameter int H_BP     = VGA_H_BP,
    parameter int V_ACTIVE = VGA_V_ACTIVE,
    parameter int V_FP     = VGA_V_FP,
    parameter int V_SYNC   = VGA_V_SYNC,
    parameter int V_BP     = VGA_V_BP
) (
    input logic              clk,
    input logic              rst_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_LO   = H_ACTIVE + H_FP;
    localparam int HS_HI   = HS_LO + H_SYNC;
    localparam int VS_LO   = V_ACTIVE + V_FP;
    localparam int VS_HI   = VS_LO + V_SYNC;

    localparam coord_t H_LAST = coord_t'(H_TOTAL - 1);
    localparam coord_t V_LAST = coord_t'(V_TOTAL - 1);

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
            $error("vga_timing_gen: H_TOTAL/V_TOTAL exceed 1024");
        end
        if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
            $error("vga_timing_gen: CLK_DIV outside 1..16");
        end
    endgenerate

    logic    tick;
    logic    first_q;
    raster_t r_q;
    raster_t r_d;
    coord_t  h_nx;
    coord_t  v_nx;

    clk_div_strobe #(
        .DIV (CLK_DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // First pixel after reset is (0,0) itself, not its successor.
    always_comb begin
        h_nx = r_q.x;
        v_nx = r_q.y;
        if (first_q) begin
            h_nx = '0;
            v_nx = '0;
        end else if (r_q.x == H_LAST) begin
            h_nx = '0;
            if (r_q.y == V_LAST) begin
                v_nx = '0;
            end else begin
                v_nx = r_q.y + 1'b1;
            end
        end else begin
            h_nx = r_q.x + 1'b1;
        end
    end

    always_comb begin
        r_d        = r_q;
        r_d.pix_en = tick;
        if (tick) begin
            r_d.x           = h_nx;
            r_d.y           = v_nx;
            r_d.active      = in_span(h_nx, 0, H_ACTIVE)
                            && in_span(v_nx, 0, V_ACTIVE);
            r_d.hsync       = !in_span(h_nx, HS_LO, HS_HI);
            r_d.vsync       = !in_span(v_nx, VS_LO, VS_HI);
            r_d.line_start  = (h_nx == '0);
            r_d.frame_start = (h_nx == '0) && (v_nx == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q     <= RASTER_RST;
            first_q <= 1'b1;
        end else begin
            r_q <= r_d;
            if (tick) begin
                first_q <= 1'b0;
            end
        end
    end

`ifdef VGA_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (tick && r_d.frame_start && !first_q) begin
            frame_cnt_q <= frame_cnt_q + 1'b1;
        end
    end

    assign vga.frame_cnt = frame_cnt_q;
`endif

    assign vga.pix_en        = r_q.pix_en;
    assign vga.xPixel        = r_q.x;
    assign vga.yPixel        = r_q.y;
    assign vga.active_pixels = r_q.active;
    assign vga.hsync         = r_q.hsync;
    assign vga.vsync         = r_q.vsync;
    assign vga.line_start    = r_q.line_start;
    assign vga.frame_start   = r_q.frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: default-timing instance plus a shrunken-timing CLK_DIV=1 instance,
// both compared every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

    typedef struct packed {
        logic       pe;
        logic [9:0] x;
        logic [9:0] y;
        logic       act;
        logic       hs;
        logic       vs;
        logic       ls;
        logic       fs;
        logic [7:0] fc;
    } obs_t;

    logic clk;
    logic rst_a;
    logic rst_b;
    longint ka;
    longint kb;
    int tests;
    int fails;

    vga_timing_gen_if ia ();
    vga_timing_gen_if ib ();

    vga_timing_gen u_a (
        .clk   (clk),
        .rst_n (rst_a),
        .vga   (ia)
    );

    vga_timing_gen #(
        .CLK_DIV  (1),
        .H_ACTIVE (8),
        .H_FP     (2),
        .H_SYNC   (3),
        .H_BP     (2),
        .V_ACTIVE (6),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (2)
    ) u_b (
        .clk   (clk),
        .rst_n (rst_b),
        .vga   (ib)
    );

    logic [7:0] fc_a;
    logic [7:0] fc_b;
`ifdef VGA_FRAME_CNT_EN
    assign fc_a = ia.frame_cnt;
    assign fc_b = ib.frame_cnt;
`else
    assign fc_a = 8'd0;
    assign fc_b = 8'd0;
`endif

    obs_t obs_a;
    obs_t obs_b;
    assign obs_a = {ia.pix_en, ia.xPixel, ia.yPixel, ia.active_pixels,
                    ia.hsync, ia.vsync, ia.line_start, ia.frame_start,
                    fc_a};
    assign obs_b = {ib.pix_en, ib.xPixel, ib.yPixel, ib.active_pixels,
                    ib.hsync, ib.vsync, ib.line_start, ib.frame_start,
                    fc_b};

    // k = rising edges seen since reset release; pixel n shows after
    // edge (n+1)*d and is described purely by n.
    function automatic obs_t model(
        input int d, input int ha, input int hf, input int hsw,
        input int hb, input int va, input int vf, input int vsw,
        input int vb, input longint k
    );
        obs_t o;
        longint n;
        int ht;
        int vt;
        int h;
        int v;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        if (k < d) return o;
        n = k / d - 1;
        h = int'(n % ht);
        v = int'((n / ht) % vt);
        o.pe = ((k % d) == 0);
        o.x = 10'(h);
        o.y = 10'(v);
        o.act = (h < ha) && (v < va);
        o.hs = !((h >= ha + hf) && (h < ha + hf + hsw));
        o.vs = !((v >= va + vf) && (v < va + vf + vsw));
        o.ls = (h == 0);
        o.fs = (h == 0) && (v == 0);
`ifdef VGA_FRAME_CNT_EN
        o.fc = 8'((n / (ht * vt)) % 256);
`endif
        return o;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req,
                     $time);
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk or negedge rst_a) begin
        if (!rst_a) ka <= 0;
        else ka <= ka + 1;
    end

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) kb <= 0;
        else kb <= kb + 1;
    end

    always @(negedge clk) begin
        chk("a_cycle", 64'(obs_a),
            64'(model(2, 640, 16, 96, 48, 480, 10, 2, 33, ka)));
        chk("b_cycle", 64'(obs_b),
            64'(model(1, 8, 2, 3, 2, 6, 1, 2, 2, kb)));
    end

    localparam logic [63:0] RST_OBS =
        64'({1'b0, 10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd0});

    initial begin
        int cnt;
        int hl;
        int mn;
        int mx;
        int ab;
        bit done;
        int seen;
        int pel;
        bit started;
        int px;
        int py;
        logic [7:0] fcs [3];
        tests = 0;
        fails = 0;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (3) @(negedge clk);
        rst_a = 1'b1;

        @(negedge clk);
        chk("a_gap_after_release", 64'(obs_a), RST_OBS);
        @(negedge clk);
        chk("a_first_pixel",
            64'({ia.pix_en, ia.xPixel, ia.yPixel, ia.active_pixels,
                 ia.frame_start, ia.line_start, ia.hsync, ia.vsync}),
            64'({1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1}));

        cnt = 1; hl = 0; mn = 1023; mx = 0; ab = 0; done = 0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            if (ia.pix_en) begin
                if (ia.line_start) begin
                    done = 1;
                end else begin
                    cnt++;
                    if (!ia.hsync) begin
                        hl++;
                        if (int'(ia.xPixel) < mn) mn = int'(ia.xPixel);
                        if (int'(ia.xPixel) > mx) mx = int'(ia.xPixel);
                    end
                    if (ia.active_pixels && int'(ia.xPixel) >= 640) ab++;
                end
            end
        end
        chk("a_line_found", 64'(done), 64'd1);
        chk("a_line_pixels", 64'(cnt), 64'd800);
        chk("a_hsync_width", 64'(hl), 64'd96);
        chk("a_hsync_first_x", 64'(mn), 64'd656);
        chk("a_hsync_last_x", 64'(mx), 64'd751);
        chk("a_active_in_blank", 64'(ab), 64'd0);
        chk("a_line_wrap",
            64'({ia.xPixel, ia.yPixel, ia.line_start, ia.frame_start}),
            64'({10'd0, 10'd1, 1'b1, 1'b0}));

        done = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (ia.pix_en && ia.xPixel == 10'd300 && ia.yPixel == 10'd1)
                done = 1;
        end
        chk("a_reach_300_1", 64'(done), 64'd1);
        @(posedge clk);
        #2 rst_a = 1'b0;
        #1 chk("a_async_reset", 64'(obs_a), RST_OBS);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        rst_a = 1'b1;
        repeat (2) @(negedge clk);
        chk("a_restart",
            64'({ia.pix_en, ia.xPixel, ia.yPixel, ia.frame_start,
                 ia.line_start, ia.active_pixels}),
            64'({1'b1, 10'd0, 10'd0, 1'b1, 1'b1, 1'b1}));

        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(1, 1500)) @(posedge clk);
            #($urandom_range(1, 4)) rst_a = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
            rst_a = 1'b1;
        end

        @(negedge clk);
        rst_b = 1'b1;
        seen = 0; pel = 0; started = 0; px = 0; py = 0;
        for (int i = 0; i < 2000 && seen < 3; i++) begin
            @(negedge clk);
            if (started && !ib.pix_en) pel++;
            if (ib.pix_en) begin
                if (started && px == 14 && py == 10)
                    chk("b_frame_wrap",
                        64'({ib.xPixel, ib.yPixel, ib.frame_start}),
                        64'({10'd0, 10'd0, 1'b1}));
                if (started && px == 14 && py == 3)
                    chk("b_line_wrap",
                        64'({ib.xPixel, ib.yPixel, ib.line_start,
                             ib.frame_start}),
                        64'({10'd0, 10'd4, 1'b1, 1'b0}));
                if (ib.frame_start) begin
                    fcs[seen] = fc_b;
                    seen++;
                end
                started = 1;
                px = int'(ib.xPixel);
                py = int'(ib.yPixel);
            end
        end
        chk("b_three_frames", 64'(seen), 64'd3);
        chk("b_pix_en_held", 64'(pel), 64'd0);
`ifdef VGA_FRAME_CNT_EN
        chk("b_fcnt_0", 64'(fcs[0]), 64'd0);
        chk("b_fcnt_1", 64'(fcs[1]), 64'd1);
        chk("b_fcnt_2", 64'(fcs[2]), 64'd2);
        begin
            logic [7:0] last_fc;
            bit wrapped;
            last_fc = fcs[2];
            wrapped = 0;
            for (int i = 0; i < 46000 && !wrapped; i++) begin
                @(negedge clk);
                if (ib.pix_en && ib.frame_start) begin
                    if (fc_b == 8'd0) begin
                        chk("b_fcnt_wrap", 64'(last_fc), 64'd255);
                        wrapped = 1;
                    end
                    last_fc = fc_b;
                end
            end
            chk("b_fcnt_wrapped", 64'(wrapped), 64'd1);
        end
`endif

        for (int r = 0; r < 5; r++) begin
            repeat ($urandom_range(1, 400)) @(posedge clk);
            #($urandom_range(1, 4)) rst_b = 1'b0;
            repeat ($urandom_range(1, 6)) @(negedge clk);
            rst_b = 1'b1;
        end
        repeat (200) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
